// File: rtl/mem_stage_pipe.sv
// Pipelined memory stage: byte-enable data memory with sign/zero-extended sub-word loads
// and a registered MEM/WB boundary carrying result, destination, valid and fault.
module mem_stage_pipe #(
  parameter int DEPTH = 256,
  parameter int RD_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic [31:0]     ALUResult,
  input  logic [31:0]     WD,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic [1:0]      Size,
  input  logic            SignExt,
  input  logic            RegWrite,
  input  logic [RD_W-1:0] Rd,
  output logic [31:0]     Result,
  output logic            RegWrite_o,
  output logic [RD_W-1:0] Rd_o,
  output logic            valid_o,
  output logic            fault_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  logic [31:0] mem [DEPTH];

  // Size 2'b11 falls into the word branches of both functions.
  function automatic logic misaligned(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] b_s;
    logic signed [31:0] h_s;
    b   = word[{lane, 3'b000} +: 8];
    h   = lane[1] ? word[31:16] : word[15:0];
    b_s = b;
    h_s = h;
    case (size)
      SZ_B:    return sext ? b_s : {24'd0, b};
      SZ_H:    return sext ? h_s : {16'd0, h};
      default: return word;
    endcase
  endfunction

  logic [AW-1:0] idx_p0;
  logic [1:0]    lane_p0;
  logic [31:0]   rd_word_p0;
  logic [31:0]   load_p0;
  logic [31:0]   wdata_p0;
  logic [3:0]    be_p0;
  logic          fault_p0;
  logic          wr_en_p0;

  // Issue stage: address decode, combinational read, fault detection.
  assign idx_p0     = ALUResult[AW+1:2];
  assign lane_p0    = ALUResult[1:0];
  assign rd_word_p0 = mem[idx_p0];
  assign load_p0    = load_extend(rd_word_p0, lane_p0, Size, SignExt);
  assign fault_p0   = valid_i & (MemWrite | MemtoReg) & misaligned(lane_p0, Size);
  // Gating with rst_n drops any store that coincides with an asserted reset.
  assign wr_en_p0   = rst_n & valid_i & MemWrite & ~stall_i & ~fault_p0;

  always_comb begin
    be_p0    = 4'b1111;
    wdata_p0 = WD;
    case (Size)
      SZ_B: begin
        be_p0    = 4'b0001 << lane_p0;
        wdata_p0 = {4{WD[7:0]}};
      end
      SZ_H: begin
        be_p0    = lane_p0[1] ? 4'b1100 : 4'b0011;
        wdata_p0 = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
  end

  // MEM/WB boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result     <= '0;
      RegWrite_o <= 1'b0;
      Rd_o       <= '0;
      valid_o    <= 1'b0;
      fault_o    <= 1'b0;
    end else if (!stall_i) begin
      if (valid_i) begin
        Result     <= fault_p0 ? 32'd0 : (MemtoReg ? load_p0 : ALUResult);
        RegWrite_o <= RegWrite & ~fault_p0;
        Rd_o       <= Rd;
        valid_o    <= 1'b1;
        fault_o    <= fault_p0;
      end else begin
        Result     <= '0;
        RegWrite_o <= 1'b0;
        Rd_o       <= '0;
        valid_o    <= 1'b0;
        fault_o    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle Mem stage of the ARM_Calculator datapath.
- Holds a DEPTH-word data memory with byte-enable writes and byte, halfword and word access modes. Loads are sign- or zero-extended.
- Result, destination and control go through a registered MEM/WB boundary, with stall and misalignment-fault handling.
- Sits between the EX stage (ALUResult, WD) and the register-file write-back.

Parameters:
- DEPTH, 256, number of 32-bit memory words; must be a power of two.
- AW, log2(DEPTH), word-index width; derived, not overridden.
- RD_W, 4, width of the destination-register tag.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  an instruction is present this cycle.
- stall_i  in  1  hold the MEM/WB register and block memory writes.
- ALUResult  in  32  byte address for loads/stores; pass-through value otherwise.
- WD  in  32  store data; the low byte or halfword is used for sub-word stores.
- MemWrite  in  1  store request.
- MemtoReg  in  1  1 = Result from memory, 0 = Result from ALUResult.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- SignExt  in  1  1 = sign-extend sub-word loads.
- RegWrite  in  1  instruction writes the register file.
- Rd  in  RD_W  destination register tag.
- Result  out  32  registered write-back value.
- RegWrite_o  out  1  registered RegWrite, qualified.
- Rd_o  out  RD_W  registered Rd.
- valid_o  out  1  registered valid.
- fault_o  out  1  registered misalignment fault.

Behaviour:
- Reset: async assert of rst_n clears Result=0, RegWrite_o=0, Rd_o=0, valid_o=0, fault_o=0 immediately. Memory contents are not reset.
- Reset mid-operation: any store sampled on the edge while rst_n=0 is discarded.
- Addressing: word index = ALUResult[AW+1:2]. Upper address bits are ignored, so the address wraps modulo 4*DEPTH. Byte lane = ALUResult[1:0].
- Misalignment:
  - halfword with ALUResult[0]=1, or word with ALUResult[1:0]!=00, is a fault.
  - Faults are checked only when valid_i=1 and (MemWrite=1 or MemtoReg=1).
  - A faulting instruction performs no write and produces Result=0, RegWrite_o=0, fault_o=1.
- Store: on a rising edge with valid_i=1, MemWrite=1, stall_i=0 and no fault, write the selected lanes:
  - byte: WD[7:0] into the addressed lane.
  - halfword: WD[15:0] into lanes {1,0} or {3,2}.
  - word: all four lanes.
  - Unselected lanes are unchanged. Little-endian lane order.
- Load: with MemtoReg=1, the addressed word is read combinationally from the array in the issue cycle.
  - The selected byte or halfword is extracted and sign- or zero-extended per SignExt, then captured into Result at the edge.
  - Latency: 1 cycle from inputs to outputs.
- Load and store in the same instruction (MemWrite=1, MemtoReg=1): Result returns the old memory contents (read-before-write).
- Store then load, back to back: a store at edge N followed by a load of the same word in cycle N+1 returns the new data. No forwarding logic is needed.
- Pass-through: MemtoReg=0 gives Result <= ALUResult.
- Stall: stall_i=1 holds all outputs and suppresses writes. Stall takes priority over valid_i.
- Bubble: valid_i=0 with stall_i=0 loads valid_o=0, RegWrite_o=0, fault_o=0, Result=0, Rd_o=0.
- Qualification: RegWrite_o = RegWrite & valid_i & ~fault.

Test Plan:
- Word store then load: store word WD=989 at ALUResult=12, then load word at 12 with MemtoReg=1 -> Result=989 one cycle later, fault_o=0.
- Byte store and extension: store word 0x000003DD at 12, then byte store WD=0x000000AB at 13. Word at 12 becomes 0x0000ABDD. Load byte at 13: SignExt=1 -> 0xFFFFFFAB; SignExt=0 -> 0x000000AB.
- Misalignment: word store WD=4554 at 14 -> fault_o=1, RegWrite_o=0, Result=0, and the word at 12 is unchanged (still 0x0000ABDD). Halfword load at 15 -> fault_o=1.
- Pass-through and wrap: MemtoReg=0, ALUResult=0x12345678 -> Result=0x12345678. With DEPTH=256, a word store at 1024+12 followed by a load at 12 returns the stored value.
- Stall: assert stall_i with a store of 7 at 16 pending -> outputs hold for the stall cycles and the word at 16 is unchanged. Release stall -> store completes and a later load of 16 returns 7.
- Async reset: drop rst_n mid-cycle while a load is in flight -> all outputs go to 0 immediately. Release rst_n -> the next instruction completes normally with 1-cycle latency.
